bus_arb_rr: RTL and testbench
=============================

# bus_arb_rr

Parametrised N-channel Wishbone arbiter that multiplexes N masters (SERV ibus/dbus, DMA engines, debug port) onto one shared slave such as the SRAM or ROM controller. It supports full read/write cycles, configurable address and data widths, fair round-robin grant ordering and a per-cycle watchdog that terminates hung slave accesses with an error. It sits between the CPU/peripheral masters and the memory slave, with one registered arbitration stage.

## Interface

Parameters:
- N, 2: number of master channels (2..8).
- AW, 32: address width.
- DW, 32: data width (multiple of 8); SW = DW/8 select lines.
- TIMEOUT, 255: cycles a granted access may wait for s_ack before error termination; 0 disables the watchdog.

Ports (clock and reset first):
- wb_clk  in  1  system clock; all state updates on the rising edge.
- wb_rst_n  in  1  reset, asynchronous, active-low.
- m_cyc  in  N  per-master cycle request; bit i = master i.
- m_we  in  N  per-master write enable.
- m_adr  in  N*AW  flattened addresses; master i at [i*AW +: AW].
- m_dat  in  N*DW  flattened write data.
- m_sel  in  N*SW  flattened byte selects.
- m_ack  out  N  per-master acknowledge.
- m_err  out  N  per-master error/timeout termination.
- m_rdt  out  DW  read data, shared by all masters; valid for master i only when m_ack[i]=1.
- s_cyc  out  1  slave cycle.
- s_we  out  1  slave write enable.
- s_adr  out  AW  slave address.
- s_dat  out  DW  slave write data.
- s_sel  out  SW  slave byte selects.
- s_ack  in  1  slave acknowledge.
- s_rdt  in  DW  slave read data.
- grant  out  N  one-hot current owner; all zero when IDLE.
- busy  out  1  equals s_cyc.

## Operation

- States: IDLE, GRANT.
- Registers: state, grant (one-hot), last (index of most recent owner, log2 N bits), holdoff (1 bit), wdog counter (width to hold TIMEOUT).
- IDLE: the request vector is m_cyc, with bit last masked when holdoff=1. If it is non-zero, pick the first set bit searching from last+1 upward, wrapping modulo N. Register grant, set last to the winner, then go to GRANT. holdoff clears every IDLE cycle.
- GRANT (owner g):
  - s_cyc = m_cyc[g]; s_we/s_adr/s_dat/s_sel = master g's fields.
  - m_ack[g] = s_ack (combinational); m_rdt = s_rdt.
  - When s_ack=1: go to IDLE, holdoff<=1, grant<=0.
  - When m_cyc[g]=0 (abort): go to IDLE, holdoff<=0.
  - When wdog reaches TIMEOUT with s_ack=0: m_err[g]=1 for that cycle, s_cyc forced 0 in that cycle, go to IDLE, holdoff<=1.
  - Priority within one cycle: ack, then abort, then timeout.
- holdoff exists because masters drop cyc one cycle after ack. It stops the just-served master being re-granted on its stale request.
- Non-owners always see m_ack=0 and m_err=0, and their requests are held pending. No request is lost.
- When IDLE, all slave outputs are 0 (s_adr, s_dat, s_sel, s_we included).

## Timing

- Reset (async, wb_rst_n=0): state=IDLE, grant=0, last=N-1 (so master 0 wins first), holdoff=0, wdog=0. All outputs are 0 immediately.
- Reset asserted mid-access drops s_cyc and m_ack at once, with no error pulse.
- Arbitration latency: a request seen in IDLE at edge k gives s_cyc=1 from cycle k+1.
- Minimum access: 2 cycles (arbitrate, then GRANT with same-cycle s_ack).
- Turnaround: at least one IDLE cycle between consecutive grants.
- wdog clears on entry to GRANT and increments each GRANT cycle without s_ack. Timeout fires in the cycle where wdog==TIMEOUT-1 (i.e. the TIMEOUT-th wait cycle).
- Fairness: with all N masters requesting continuously, each is granted exactly once in every N grants.

## Test plan

- Single master: N=2, m_cyc=01, m_adr[0]=0x100. Slave acks on the 1st GRANT cycle, s_rdt=0xDEADBEEF. Required: s_cyc high for exactly 1 cycle, m_ack=01, m_rdt=0xDEADBEEF. Master 0 still holding cyc in the next cycle is not re-granted.
- Round-robin: N=4, all m_cyc=1111, slave acks immediately, held for 8 grants. Required: grant order 0,1,2,3,0,1,2,3.
- Write pass-through: master 2 asserts we=1, adr=0x2000_0004, dat=0x12345678, sel=0xC. Required: s_* match exactly, and masters 0, 1 and 3 see m_ack=0.
- Timeout: TIMEOUT=4, slave never acks. Required: m_err[g]=1 in the 4th GRANT cycle, then IDLE, and the next waiting master is granted afterwards.
- Abort: the owner drops m_cyc in its 2nd GRANT cycle without ack. Required: s_cyc=0 that cycle, no m_ack and no m_err, and re-arbitration on the next edge.
- Async reset: assert wb_rst_n=0 mid-GRANT between clock edges. Required: s_cyc, grant and m_ack go to 0 immediately. After release, master 0 wins the first arbitration.

Source files
------------

// File: rtl/bus_arb_rr.sv
// Purpose : N-channel round-robin Wishbone arbiter multiplexing masters onto one slave.
// Latency : one registered arbitration cycle (request in IDLE -> s_cyc next cycle).
// Backpres: non-owners are held pending (no ack/err); owner stalls until s_ack, abort or watchdog.
//
// Ports:
//   wb_clk, wb_rst_n           clock, async active-low reset
//   m_cyc/m_we/m_adr/m_dat/m_sel  per-master request bundle (flattened, master i at slot i)
//   m_ack/m_err/m_rdt          per-master termination, shared read data
//   s_cyc/s_we/s_adr/s_dat/s_sel, s_ack/s_rdt  shared slave port
//   grant (one-hot owner), busy (= s_cyc)
module bus_arb_rr #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic [N-1:0]          m_cyc,
  input  logic [N-1:0]          m_we,
  input  logic [N*AW-1:0]       m_adr,
  input  logic [N*DW-1:0]       m_dat,
  input  logic [N*(DW/8)-1:0]   m_sel,
  output logic [N-1:0]          m_ack,
  output logic [N-1:0]          m_err,
  output logic [DW-1:0]         m_rdt,
  output logic                  s_cyc,
  output logic                  s_we,
  output logic [AW-1:0]         s_adr,
  output logic [DW-1:0]         s_dat,
  output logic [DW/8-1:0]       s_sel,
  input  logic                  s_ack,
  input  logic [DW-1:0]         s_rdt,
  output logic [N-1:0]          grant,
  output logic                  busy
);

  localparam int SW = DW / 8;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    r_state;
  logic [N-1:0]  r_grant;
  logic [LW-1:0] r_last;
  logic          r_holdoff;
  logic [WW-1:0] r_wdog;

  logic          w_in_grant;
  logic          w_own_cyc;
  logic          w_own_we;
  logic [AW-1:0] w_own_adr;
  logic [DW-1:0] w_own_dat;
  logic [SW-1:0] w_own_sel;
  logic [N-1:0]  w_last_oh;
  logic [N-1:0]  w_req;
  logic          w_found;
  logic [LW-1:0] w_win;
  logic [N-1:0]  w_win_oh;
  logic          w_ack;
  logic          w_tmo;

  assign w_in_grant = (r_state == ST_GRANT);

  // Owner is always the most recent winner, so r_last doubles as the mux select.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_we  = 1'b0;
    w_own_adr = '0;
    w_own_dat = '0;
    w_own_sel = '0;
    w_last_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (r_last == LW'(i)) begin
        w_own_cyc    = m_cyc[i];
        w_own_we     = m_we[i];
        w_own_adr    = m_adr[i*AW +: AW];
        w_own_dat    = m_dat[i*DW +: DW];
        w_own_sel    = m_sel[i*SW +: SW];
        w_last_oh[i] = 1'b1;
      end
    end
  end

  // Round-robin search starting just after the previous owner; the previous
  // owner itself is visited last, and is masked entirely while holdoff is set
  // so its stale post-ack request cannot win.
  always_comb begin
    int idx;
    w_req    = m_cyc & ~(r_holdoff ? w_last_oh : '0);
    w_found  = 1'b0;
    w_win    = r_last;
    w_win_oh = '0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_last) + k) % N;
      if (!w_found && w_req[idx]) begin
        w_found       = 1'b1;
        w_win         = LW'(idx);
        w_win_oh[idx] = 1'b1;
      end
    end
  end

  // Termination priority: ack, then abort, then watchdog.
  assign w_ack = w_in_grant & s_ack;
  assign w_tmo = WDOG_EN & w_in_grant & ~s_ack & w_own_cyc & (r_wdog == WDOG_LAST);

  assign s_cyc = w_in_grant & w_own_cyc & ~w_tmo;
  assign s_we  = w_in_grant & w_own_we;
  assign s_adr = w_in_grant ? w_own_adr : '0;
  assign s_dat = w_in_grant ? w_own_dat : '0;
  assign s_sel = w_in_grant ? w_own_sel : '0;
  assign m_ack = w_ack ? r_grant : '0;
  assign m_err = w_tmo ? r_grant : '0;
  assign m_rdt = w_in_grant ? s_rdt : '0;
  assign grant = r_grant;
  assign busy  = s_cyc;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_last    <= LW'(N - 1);
      r_holdoff <= 1'b0;
      r_wdog    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_holdoff <= 1'b0;
          r_wdog    <= '0;
          if (w_found) begin
            r_state <= ST_GRANT;
            r_grant <= w_win_oh;
            r_last  <= w_win;
          end
        end
        ST_GRANT: begin
          if (s_ack) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_holdoff <= 1'b1;
          end else if (!w_own_cyc) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_holdoff <= 1'b0;
          end else if (w_tmo) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_holdoff <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb_rr.sv
// Purpose : directed self-checking bench for bus_arb_rr (N=4, TIMEOUT=4).
// Latency : inputs driven 2 time units after the rising edge, outputs sampled 1 unit later.
// Backpres: slave ack driven directly as directed stimulus.
module tb_bus_arb_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              wb_clk;
  logic              wb_rst_n;
  logic [N-1:0]      m_cyc;
  logic [N-1:0]      m_we;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [N*SW-1:0]   m_sel;
  logic [N-1:0]      m_ack;
  logic [N-1:0]      m_err;
  logic [DW-1:0]     m_rdt;
  logic              s_cyc;
  logic              s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat;
  logic [SW-1:0]     s_sel;
  logic              s_ack;
  logic [DW-1:0]     s_rdt;
  logic [N-1:0]      grant;
  logic              busy;

  int n_chk  = 0;
  int n_pass = 0;

  bus_arb_rr #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .m_cyc   (m_cyc),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat   (m_dat),
    .m_sel   (m_sel),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rdt   (m_rdt),
    .s_cyc   (s_cyc),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dat   (s_dat),
    .s_sel   (s_sel),
    .s_ack   (s_ack),
    .s_rdt   (s_rdt),
    .grant   (grant),
    .busy    (busy)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge wb_clk);
    #2;
  endtask

  initial begin
    wb_rst_n = 1'b0;
    m_cyc = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = 1'b0; s_rdt = '0;
    m_adr[0*AW +: AW] = 32'h0000_0100;
    m_adr[1*AW +: AW] = 32'h1111_0000;
    m_adr[2*AW +: AW] = 32'h2000_0004;
    m_adr[3*AW +: AW] = 32'h3333_0000;
    m_dat[0*DW +: DW] = 32'hA0A0_A0A0;
    m_dat[1*DW +: DW] = 32'hB1B1_B1B1;
    m_dat[2*DW +: DW] = 32'h1234_5678;
    m_dat[3*DW +: DW] = 32'hD3D3_D3D3;
    m_sel[0*SW +: SW] = 4'hF;
    m_sel[1*SW +: SW] = 4'h3;
    m_sel[2*SW +: SW] = 4'hC;
    m_sel[3*SW +: SW] = 4'h1;
    #1;
    // Reset state
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_s_cyc", 64'(s_cyc), 64'h0);
    chk("rst_m_ack", 64'(m_ack), 64'h0);
    chk("rst_s_adr", 64'(s_adr), 64'h0);
    #11;
    wb_rst_n = 1'b1;

    // Single master read
    m_cyc = 4'b0001;
    #1;
    chk("single_idle_s_cyc", 64'(s_cyc), 64'h0);
    step();
    s_ack = 1'b1; s_rdt = 32'hDEAD_BEEF;
    #1;
    chk("single_s_cyc", 64'(s_cyc), 64'h1);
    chk("single_busy", 64'(busy), 64'h1);
    chk("single_s_adr", 64'(s_adr), 64'h100);
    chk("single_s_we", 64'(s_we), 64'h0);
    chk("single_grant", 64'(grant), 64'b0001);
    chk("single_m_ack", 64'(m_ack), 64'b0001);
    chk("single_m_rdt", 64'(m_rdt), 64'hDEAD_BEEF);
    step();
    s_ack = 1'b0;
    #1;
    chk("single_after_s_cyc", 64'(s_cyc), 64'h0);
    chk("single_after_grant", 64'(grant), 64'h0);
    step();
    chk("single_no_regrant_s_cyc", 64'(s_cyc), 64'h0);
    chk("single_no_regrant_grant", 64'(grant), 64'h0);

    // Async reset mid-GRANT
    m_cyc = 4'b0010;
    step();
    chk("rstmid_grant", 64'(grant), 64'b0010);
    chk("rstmid_s_adr", 64'(s_adr), 64'h1111_0000);
    s_ack = 1'b1;
    #1;
    chk("rstmid_m_ack_before", 64'(m_ack), 64'b0010);
    wb_rst_n = 1'b0;
    #1;
    chk("rstmid_s_cyc", 64'(s_cyc), 64'h0);
    chk("rstmid_grant0", 64'(grant), 64'h0);
    chk("rstmid_m_ack", 64'(m_ack), 64'h0);
    chk("rstmid_m_err", 64'(m_err), 64'h0);
    #1;
    wb_rst_n = 1'b1;

    // Round-robin with all masters requesting and immediate ack
    m_cyc = 4'b1111;
    s_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] exp_oh;
      exp_oh = 4'b0001 << (i % 4);
      step();
      chk($sformatf("rr_grant_%0d", i), 64'(grant), 64'(exp_oh));
      chk($sformatf("rr_m_ack_%0d", i), 64'(m_ack), 64'(exp_oh));
      step();
      chk($sformatf("rr_turnaround_%0d", i), 64'(grant), 64'h0);
    end

    // Write pass-through from master 2
    m_cyc = 4'b0100;
    m_we  = 4'b0100;
    s_ack = 1'b0;
    step();
    chk("wr_grant", 64'(grant), 64'b0100);
    chk("wr_s_cyc", 64'(s_cyc), 64'h1);
    chk("wr_s_we", 64'(s_we), 64'h1);
    chk("wr_s_adr", 64'(s_adr), 64'h2000_0004);
    chk("wr_s_dat", 64'(s_dat), 64'h1234_5678);
    chk("wr_s_sel", 64'(s_sel), 64'hC);
    s_ack = 1'b1;
    #1;
    chk("wr_m_ack", 64'(m_ack), 64'b0100);
    chk("wr_m_err", 64'(m_err), 64'h0);
    step();
    m_cyc = '0; m_we = '0; s_ack = 1'b0;
    #1;
    chk("idle_s_cyc", 64'(s_cyc), 64'h0);
    chk("idle_s_we", 64'(s_we), 64'h0);
    chk("idle_s_adr", 64'(s_adr), 64'h0);
    chk("idle_s_dat", 64'(s_dat), 64'h0);
    chk("idle_s_sel", 64'(s_sel), 64'h0);

    // Watchdog timeout: master 0 granted (search starts after 2), slave never acks
    m_cyc = 4'b0011;
    step();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("tmo_grant_c%0d", c), 64'(grant), 64'b0001);
      chk($sformatf("tmo_m_err_c%0d", c), 64'(m_err), (c == 4) ? 64'b0001 : 64'h0);
      chk($sformatf("tmo_s_cyc_c%0d", c), 64'(s_cyc), (c == 4) ? 64'h0 : 64'h1);
      chk($sformatf("tmo_m_ack_c%0d", c), 64'(m_ack), 64'h0);
      if (c < 4) step();
    end
    step();
    chk("tmo_idle_grant", 64'(grant), 64'h0);
    chk("tmo_idle_m_err", 64'(m_err), 64'h0);
    step();
    chk("tmo_next_grant", 64'(grant), 64'b0010);
    chk("tmo_next_s_adr", 64'(s_adr), 64'h1111_0000);

    // Abort: master 1 drops cyc in its 2nd GRANT cycle
    step();
    m_cyc = 4'b0001;
    #1;
    chk("abort_s_cyc", 64'(s_cyc), 64'h0);
    chk("abort_m_ack", 64'(m_ack), 64'h0);
    chk("abort_m_err", 64'(m_err), 64'h0);
    step();
    chk("abort_idle_grant", 64'(grant), 64'h0);
    step();
    chk("abort_rearb_grant", 64'(grant), 64'b0001);
    chk("abort_rearb_s_cyc", 64'(s_cyc), 64'h1);
    s_ack = 1'b1;
    #1;
    chk("abort_rearb_m_ack", 64'(m_ack), 64'b0001);
    step();
    m_cyc = '0; s_ack = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
